bludger_controller: RTL and testbench
=====================================

BLUDGER_CONTROLLER -- requirements
Module: bludger_controller

Interface
REQ-001 Parameter BALL_RADIUS, default 10: bludger radius in px.
REQ-002 Parameter PLAYER_RADIUS, default 25: target player radius in px.
REQ-003 Parameter INITIAL_X / INITIAL_Y, default 320 / 240: ball centre after reset.
REQ-004 Parameter MOVEMENT_FREQUENCY, default 200000: clk cycles per 1 px movement step; SHALL be >= 2.
REQ-005 Parameter LEFT_BOUNDARY / RIGHT_BOUNDARY / TOP_BOUNDARY / BOT_BOUNDARY, default 0 / 639 / 0 / 479: arena limits in px.
REQ-006 Parameter COOLDOWN_TICKS, default 50: movement ticks after release during which collisions are ignored.
REQ-007 clk  input  1  system clock; all state changes on posedge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 player_x  input  10  target player centre X.
REQ-010 player_y  input  10  target player centre Y.
REQ-011 clean_bludge  input  1  player controller done serving bludge penalty.
REQ-012 ball_x  output  10  registered bludger centre X.
REQ-013 ball_y  output  10  registered bludger centre Y.
REQ-014 bludged  output  1  registered; high while player is frozen by a hit.
REQ-015 hit_count  output  4  registered; saturating count of hits since reset.

Function
REQ-016 States: ROAM, HIT, ESCAPE; two-bit encoding; no other reachable state.
REQ-017 Tick counter: increments every cycle in ROAM and ESCAPE; tick asserted when counter == MOVEMENT_FREQUENCY-1, counter then wraps to 0; held at 0 in HIT.
REQ-018 Direction flags dir_x, dir_y (1 = increasing coordinate); on each tick in ROAM/ESCAPE each axis moves by exactly 1 px in its direction.
REQ-019 Bounce X: on tick, if dir_x=1 and ball_x >= RIGHT_BOUNDARY-BALL_RADIUS, or dir_x=0 and ball_x <= LEFT_BOUNDARY+BALL_RADIUS, dir_x toggles and ball_x is unchanged that tick.
REQ-020 Bounce Y: same rule on ball_y with TOP_BOUNDARY/BOT_BOUNDARY, independent of X.
REQ-021 Collision: |ball_x-player_x|^2 + |ball_y-player_y|^2 < (BALL_RADIUS+PLAYER_RADIUS)^2, evaluated every cycle, unsigned, at least 21-bit intermediates, no overflow or wrap.
REQ-022 ROAM -> HIT on the edge where collision is true; bludged=1 and hit_count+1 (saturate at 15) on that edge; ball does not move on that edge even if tick coincides.
REQ-023 HIT: ball_x, ball_y, dir flags frozen; bludged held 1; collision ignored.
REQ-024 HIT -> ESCAPE on first edge with clean_bludge=1; bludged=0 on that edge; dir_x and dir_y both inverted on that edge.
REQ-025 ESCAPE: moves per REQ-018..020; collision ignored; cooldown counter counts ticks; -> ROAM on the edge of the COOLDOWN_TICKS-th tick.
REQ-026 clean_bludge in ROAM or ESCAPE SHALL be ignored.
REQ-027 clean_bludge and tick in same HIT cycle: transition per REQ-024, no movement that edge.
REQ-028 Player at ball centre (distance 0) counts as collision.

Reset
REQ-029 rst_n=0 SHALL immediately force: state ROAM, ball_x=INITIAL_X, ball_y=INITIAL_Y, dir_x=1, dir_y=1, bludged=0, hit_count=0, tick and cooldown counters 0.
REQ-030 Reset asserted in HIT SHALL drop bludged asynchronously, without waiting for clk.
REQ-031 After rst_n rises, first tick occurs MOVEMENT_FREQUENCY edges later.

Verification (MOVEMENT_FREQUENCY=4, defaults otherwise)
REQ-032 Player at (100,100), reset release -> ball at (321,241) after 4 edges, (322,242) after 8; bludged=0.
REQ-033 Ball steered to x=629 with dir_x=1 -> next tick x stays 629, dir_x=0, following tick x=628.
REQ-034 Player placed at (ball_x+34, ball_y) -> next edge bludged=1, hit_count=1, position frozen for 1000 cycles.
REQ-035 In HIT, pulse clean_bludge 1 cycle -> bludged=0 same edge, directions inverted, no re-hit for 50 ticks despite overlap, ROAM after tick 50.
REQ-036 Hit 16 times -> hit_count stays 15; rst_n low during HIT -> bludged=0 before next clk edge, ball back at (320,240).

Source files
------------

// File: rtl/bludger_controller.sv
// bludger_controller: bouncing bludger that freezes a player on contact, then escapes with a collision cooldown
module bludger_controller #(
  parameter int BALL_RADIUS        = 10,
  parameter int PLAYER_RADIUS      = 25,
  parameter int INITIAL_X          = 320,
  parameter int INITIAL_Y          = 240,
  parameter int MOVEMENT_FREQUENCY = 200000,
  parameter int LEFT_BOUNDARY      = 0,
  parameter int RIGHT_BOUNDARY     = 639,
  parameter int TOP_BOUNDARY       = 0,
  parameter int BOT_BOUNDARY       = 479,
  parameter int COOLDOWN_TICKS     = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic       clean_bludge,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       bludged,
  output logic [3:0] hit_count
);
  localparam int TW = $clog2(MOVEMENT_FREQUENCY);
  localparam int CW = $clog2(COOLDOWN_TICKS + 1);
  localparam logic [9:0] X_MIN = 10'(LEFT_BOUNDARY + BALL_RADIUS);
  localparam logic [9:0] X_MAX = 10'(RIGHT_BOUNDARY - BALL_RADIUS);
  localparam logic [9:0] Y_MIN = 10'(TOP_BOUNDARY + BALL_RADIUS);
  localparam logic [9:0] Y_MAX = 10'(BOT_BOUNDARY - BALL_RADIUS);
  localparam logic [21:0] HIT_D2 = 22'((BALL_RADIUS + PLAYER_RADIUS) * (BALL_RADIUS + PLAYER_RADIUS));
  typedef enum logic [1:0] {ROAM = 2'd0, HIT = 2'd1, ESCAPE = 2'd2} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tick_cnt, tick_cnt_nx;
  logic [CW-1:0] cool_cnt, cool_cnt_nx;
  logic [9:0] ball_x_nx, ball_y_nx, dx, dy;
  logic [21:0] dist2;
  logic [3:0] hit_count_nx;
  logic dir_x, dir_y, dir_x_nx, dir_y_nx, bludged_nx;
  logic tick, collide, move, edge_x, edge_y;
  // 22-bit sum of squares cannot overflow for 10-bit deltas
  always_comb begin
    dx = ball_x >= player_x ? ball_x - player_x : player_x - ball_x;
    dy = ball_y >= player_y ? ball_y - player_y : player_y - ball_y;
    dist2 = 22'(dx) * 22'(dx) + 22'(dy) * 22'(dy);
    collide = dist2 < HIT_D2;
    tick = state != HIT && tick_cnt == TW'(MOVEMENT_FREQUENCY - 1);
  end
  always_comb begin
    state_nx = state;
    bludged_nx = bludged;
    hit_count_nx = hit_count;
    cool_cnt_nx = cool_cnt;
    dir_x_nx = dir_x;
    dir_y_nx = dir_y;
    ball_x_nx = ball_x;
    ball_y_nx = ball_y;
    move = 1'b0;
    edge_x = dir_x ? ball_x >= X_MAX : ball_x <= X_MIN;
    edge_y = dir_y ? ball_y >= Y_MAX : ball_y <= Y_MIN;
    case (state)
      ROAM: begin
        state_nx = collide ? HIT : ROAM;
        bludged_nx = collide;
        hit_count_nx = collide && hit_count != 4'd15 ? hit_count + 4'd1 : hit_count;
        move = tick && !collide;
      end
      HIT: begin
        state_nx = clean_bludge ? ESCAPE : HIT;
        bludged_nx = !clean_bludge;
        dir_x_nx = clean_bludge ? ~dir_x : dir_x;
        dir_y_nx = clean_bludge ? ~dir_y : dir_y;
        cool_cnt_nx = '0;
      end
      ESCAPE: begin
        move = tick;
        state_nx = tick && cool_cnt == CW'(COOLDOWN_TICKS - 1) ? ROAM : ESCAPE;
        cool_cnt_nx = !tick ? cool_cnt : state_nx == ROAM ? '0 : cool_cnt + CW'(1);
      end
      default: state_nx = ROAM;
    endcase
    if (move) begin
      dir_x_nx = edge_x ? ~dir_x : dir_x;
      dir_y_nx = edge_y ? ~dir_y : dir_y;
      ball_x_nx = edge_x ? ball_x : dir_x ? ball_x + 10'd1 : ball_x - 10'd1;
      ball_y_nx = edge_y ? ball_y : dir_y ? ball_y + 10'd1 : ball_y - 10'd1;
    end
    tick_cnt_nx = state == HIT || state_nx == HIT || tick ? '0 : tick_cnt + TW'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ROAM;
      ball_x <= 10'(INITIAL_X);
      ball_y <= 10'(INITIAL_Y);
      dir_x <= 1'b1;
      dir_y <= 1'b1;
      bludged <= 1'b0;
      hit_count <= '0;
      tick_cnt <= '0;
      cool_cnt <= '0;
    end else begin
      state <= state_nx;
      ball_x <= ball_x_nx;
      ball_y <= ball_y_nx;
      dir_x <= dir_x_nx;
      dir_y <= dir_y_nx;
      bludged <= bludged_nx;
      hit_count <= hit_count_nx;
      tick_cnt <= tick_cnt_nx;
      cool_cnt <= cool_cnt_nx;
    end
  end
endmodule

// File: tb/tb_bludger_controller.sv
// tb_bludger_controller: random and directed stimulus checked every cycle against a behavioural bludger model
module tb_bludger_controller;
  localparam int MF = 4;
  logic clk = 1'b0, rst_n = 1'b0, clean_bludge = 1'b0;
  logic [9:0] player_x = 10'd1023, player_y = 10'd1023;
  logic [9:0] ball_x, ball_y;
  logic bludged;
  logic [3:0] hit_count;
  int total = 0, bad = 0;
  bit chk_en = 1'b0;
  int m_x, m_y, m_dx, m_dy, m_mode, m_edges, m_cool, m_hits, m_bl;

  bludger_controller #(.MOVEMENT_FREQUENCY(MF)) dut (
    .clk(clk), .rst_n(rst_n), .player_x(player_x), .player_y(player_y),
    .clean_bludge(clean_bludge), .ball_x(ball_x), .ball_y(ball_y),
    .bludged(bludged), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Mode 0 roam, 1 frozen by hit, 2 escaping; m_edges counts edges spent moving
  always @(posedge clk or negedge rst_n) begin : model
    int x, y, dx, dy, mode, edges, cool, hits, bl, ex, ey;
    if (!rst_n) begin
      m_x <= 320; m_y <= 240; m_dx <= 1; m_dy <= 1; m_mode <= 0;
      m_edges <= 0; m_cool <= 0; m_hits <= 0; m_bl <= 0;
    end else begin
      x = m_x; y = m_y; dx = m_dx; dy = m_dy; mode = m_mode;
      edges = m_edges; cool = m_cool; hits = m_hits; bl = m_bl;
      ex = x - int'(player_x);
      ey = y - int'(player_y);
      if (mode == 0 && ex * ex + ey * ey < 35 * 35) begin
        mode = 1; bl = 1; edges = 0;
        if (hits < 15) hits++;
      end else if (mode == 1) begin
        edges = 0;
        if (clean_bludge) begin
          mode = 2; bl = 0; dx = -dx; dy = -dy; cool = 0;
        end
      end else begin
        edges++;
        if (edges % MF == 0) begin
          if (dx > 0 ? x >= 629 : x <= 10) dx = -dx; else x += dx;
          if (dy > 0 ? y >= 469 : y <= 10) dy = -dy; else y += dy;
          if (mode == 2) begin
            cool++;
            if (cool == 50) mode = 0;
          end
        end
      end
      m_x <= x; m_y <= y; m_dx <= dx; m_dy <= dy; m_mode <= mode;
      m_edges <= edges; m_cool <= cool; m_hits <= hits; m_bl <= bl;
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("ball_x", int'(ball_x), m_x);
    check("ball_y", int'(ball_y), m_y);
    check("bludged", int'(bludged), m_bl);
    check("hit_count", int'(hit_count), m_hits);
  end

  task automatic pulse_clean();
    clean_bludge = 1'b1;
    @(negedge clk);
    clean_bludge = 1'b0;
  endtask

  task automatic track_until_hit(output int n);
    n = 0;
    while (n < 400) begin
      player_x = 10'(m_x);
      player_y = 10'(m_y);
      @(negedge clk);
      n++;
      if (bludged) break;
    end
  endtask

  initial begin
    int n, hx, hy, px, py;
    repeat (2) @(negedge clk);
    check("rst_x", int'(ball_x), 320);
    check("rst_y", int'(ball_y), 240);
    check("rst_bludged", int'(bludged), 0);
    check("rst_hits", int'(hit_count), 0);
    player_x = 10'd100; player_y = 10'd100;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_x", int'(ball_x), 321);
    check("t4_y", int'(ball_y), 241);
    repeat (4) @(negedge clk);
    check("t8_x", int'(ball_x), 322);
    check("t8_y", int'(ball_y), 242);
    check("t8_bludged", int'(bludged), 0);
    // right wall bounce
    player_x = 10'd1023; player_y = 10'd1023;
    for (int i = 0; i < 2000 && !(m_x == 629 && m_dx == 1); i++) @(negedge clk);
    check("reach_629", int'(ball_x), 629);
    repeat (4) @(negedge clk);
    check("bounce_hold", int'(ball_x), 629);
    repeat (4) @(negedge clk);
    check("bounce_back", int'(ball_x), 628);
    // hit at distance 34
    hx = m_x; hy = m_y;
    player_x = 10'(hx + 34); player_y = 10'(hy);
    @(negedge clk);
    check("hit_bludged", int'(bludged), 1);
    check("hit_count1", int'(hit_count), 1);
    repeat (1000) @(negedge clk);
    check("frozen_x", int'(ball_x), hx);
    check("frozen_y", int'(ball_y), hy);
    check("frozen_bludged", int'(bludged), 1);
    pulse_clean();
    check("clean_drop", int'(bludged), 0);
    track_until_hit(n);
    check("rehit_edges", n, 201);
    check("hit_count2", int'(hit_count), 2);
    for (int k = 0; k < 14; k++) begin
      repeat ($urandom_range(1, 6)) @(negedge clk);
      pulse_clean();
      track_until_hit(n);
      check("rehit_loop", int'(bludged), 1);
    end
    check("hit_sat", int'(hit_count), 15);
    // asynchronous reset while frozen
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_bludged", int'(bludged), 0);
    check("async_x", int'(ball_x), 320);
    check("async_y", int'(ball_y), 240);
    check("async_hits", int'(hit_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 9))
        0, 1: begin
          px = m_x + int'($urandom_range(0, 80)) - 40;
          py = m_y + int'($urandom_range(0, 80)) - 40;
          player_x = 10'(px < 0 ? 0 : px);
          player_y = 10'(py < 0 ? 0 : py);
        end
        2, 3: ;
        default: begin
          player_x = 10'($urandom_range(700, 1023));
          player_y = 10'($urandom_range(0, 1023));
        end
      endcase
      clean_bludge = $urandom_range(0, 15) == 0;
    end
    clean_bludge = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
